// File: rtl/toupper_pkg.sv
// Shared types and constants for the upper-case stream arbiter.
// Holds the arbiter FSM states, source tags, ASCII bounds and the output beat layout.
package toupper_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam logic [7:0] ASCII_LC_LO = 8'h61;
  localparam logic [7:0] ASCII_LC_HI = 8'h7A;
  localparam logic [7:0] CASE_BIT    = 8'h20;

  typedef struct packed {
    logic       src;
    logic       last;
    logic [7:0] data;
  } beat_t;

  // Lowercase ASCII letters lose the case bit; every other byte passes through.
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= ASCII_LC_LO && c <= ASCII_LC_HI) begin
      return c - CASE_BIT;
    end
    return c;
  endfunction

endpackage

// File: rtl/toupper.sv
// Combinational ASCII toUpper: lowercase letters map to uppercase, all else unchanged.
module toupper
  import toupper_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  assign y = to_upper(x);

endmodule

// File: rtl/upper_stream_arbiter.sv
// Round-robin packet arbiter for two byte streams feeding one shared toUpper and
// a single registered output stage, with conversion counting and a mid-packet watchdog.
module upper_stream_arbiter
  import toupper_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [7:0]       a_data,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [7:0]       b_data,
  input  logic             b_last,
  input  logic             en_upper,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             m_src,
  output logic [CNT_W-1:0] conv_cnt,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 2);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  arb_state_e        state_q, state_d;
  logic              rr_q, rr_d;
  logic              en_q, en_d;
  beat_t             out_q, out_d;
  logic              m_valid_q, m_valid_d;
  logic [CNT_W-1:0]  conv_q, conv_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              tout_q, tout_d;

  logic       grant_b;
  logic       granted;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;
  logic [7:0] up_data;
  logic [7:0] conv_data;
  logic       slot_free;
  logic       accept;

  // Granted requester's beat feeds the shared converter.
  assign grant_b   = (state_q == GRANT_B);
  assign granted   = (state_q != IDLE);
  assign sel_valid = grant_b ? b_valid : a_valid;
  assign sel_last  = grant_b ? b_last  : a_last;
  assign sel_data  = grant_b ? b_data  : a_data;

  toupper u_toupper (
    .x (sel_data),
    .y (up_data)
  );

  assign conv_data = en_q ? up_data : sel_data;
  assign slot_free = !m_valid_q || m_ready;
  assign accept    = granted && sel_valid && slot_free;

  assign a_ready = (state_q == GRANT_A) && slot_free;
  assign b_ready = (state_q == GRANT_B) && slot_free;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    en_d      = en_q;
    out_d     = out_q;
    m_valid_d = m_valid_q;
    conv_d    = conv_q;
    idle_d    = idle_q;
    tout_d    = 1'b0;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    // A new beat overwrites the slot only when it is empty or draining this cycle.
    if (accept) begin
      m_valid_d  = 1'b1;
      out_d.src  = grant_b ? SRC_B : SRC_A;
      out_d.last = sel_last;
      out_d.data = conv_data;
      if (conv_data != sel_data && conv_q != CNT_MAX) begin
        conv_d = conv_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        en_d   = en_upper;
        idle_d = '0;
        if (a_valid && (!b_valid || rr_q == SRC_A)) begin
          state_d = GRANT_A;
        end else if (b_valid) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A, GRANT_B: begin
        if (accept) begin
          idle_d = '0;
          if (sel_last) begin
            state_d = IDLE;
            rr_d    = grant_b ? SRC_A : SRC_B;
          end
        end else if (!sel_valid && TIMEOUT != 0) begin
          // Starved grant: abandon the packet and hand priority to the other side.
          if (idle_q == IDLE_LIMIT) begin
            tout_d  = 1'b1;
            state_d = IDLE;
            rr_d    = grant_b ? SRC_A : SRC_B;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= SRC_A;
      en_q      <= 1'b0;
      out_q     <= '0;
      m_valid_q <= 1'b0;
      conv_q    <= '0;
      idle_q    <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      en_q      <= en_d;
      out_q     <= out_d;
      m_valid_q <= m_valid_d;
      conv_q    <= conv_d;
      idle_q    <= idle_d;
      tout_q    <= tout_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = out_q.data;
  assign m_last      = out_q.last;
  assign m_src       = out_q.src;
  assign conv_cnt    = conv_q;
  assign timeout_err = tout_q;
  assign busy        = (state_q != IDLE) || m_valid_q;

endmodule

// File: tb/tb_upper_stream_arbiter.sv
// Directed bench for upper_stream_arbiter: default instance plus a CNT_W=2 instance
// sharing the same stimulus for the counter saturation case.
module tb_upper_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_last, b_valid, b_last, en_upper, m_ready;
  logic [7:0]  a_data, b_data;
  logic        a_ready, b_ready, m_valid, m_last, m_src, busy, timeout_err;
  logic [7:0]  m_data;
  logic [15:0] conv_cnt;

  logic        a_ready2, b_ready2, m_valid2, m_last2, m_src2, busy2, timeout_err2;
  logic [7:0]  m_data2;
  logic [1:0]  conv_cnt2;

  int checks = 0;
  int errors = 0;

  logic [9:0] mon_q[$];
  logic [7:0] pkt[$];
  logic [9:0] exp_b[6];

  always #5 clk = ~clk;

  upper_stream_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
    .en_upper(en_upper),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_src(m_src),
    .conv_cnt(conv_cnt), .busy(busy), .timeout_err(timeout_err)
  );

  upper_stream_arbiter #(.CNT_W(2), .TIMEOUT(16)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready2), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready2), .b_data(b_data), .b_last(b_last),
    .en_upper(en_upper),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2), .m_src(m_src2),
    .conv_cnt(conv_cnt2), .busy(busy2), .timeout_err(timeout_err2)
  );

  // Record every beat that transfers at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) mon_q.push_back({m_src, m_last, m_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; a_last = 1'b0; a_data = 8'h00;
    b_valid = 1'b0; b_last = 1'b0; b_data = 8'h00;
    en_upper = 1'b1; m_ready = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  // Drive pkt on requester A, holding each beat until it is accepted.
  task automatic send_a();
    logic taken;
    for (int i = 0; i < pkt.size(); i++) begin
      a_valid = 1'b1;
      a_data  = pkt[i];
      a_last  = (i == pkt.size() - 1);
      taken   = 1'b0;
      for (int c = 0; c < 50 && !taken; c++) begin
        @(negedge clk);
        taken = a_ready;
        step();
      end
      check("send_accept", 32'(taken), 32'd1);
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  initial begin
    exp_b[0] = {1'b0, 1'b0, 8'h41};
    exp_b[1] = {1'b0, 1'b0, 8'h60};
    exp_b[2] = {1'b0, 1'b0, 8'h7B};
    exp_b[3] = {1'b0, 1'b0, 8'h5B};
    exp_b[4] = {1'b0, 1'b1, 8'h40};
    exp_b[5] = {1'b0, 1'b1, 8'h61};

    // Reset values
    do_reset();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_src", 32'(m_src), 32'd0);
    check("rst_conv_cnt", 32'(conv_cnt), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // 1: two-beat A packet, converted, 1-cycle latency
    a_valid = 1'b1; a_data = 8'h61; a_last = 1'b0;
    step();
    check("t1_grant_ready", 32'(a_ready), 32'd1);
    check("t1_no_out_yet", 32'(m_valid), 32'd0);
    step();
    check("t1_b0_valid", 32'(m_valid), 32'd1);
    check("t1_b0_data", 32'(m_data), 32'h41);
    check("t1_b0_last", 32'(m_last), 32'd0);
    check("t1_b0_src", 32'(m_src), 32'd0);
    a_data = 8'h62; a_last = 1'b1;
    step();
    check("t1_b1_data", 32'(m_data), 32'h42);
    check("t1_b1_last", 32'(m_last), 32'd1);
    check("t1_conv_cnt", 32'(conv_cnt), 32'd2);
    a_valid = 1'b0; a_last = 1'b0;
    step();
    check("t1_drained", 32'(m_valid), 32'd0);

    // 2: contention after reset, bubble, then alternate
    do_reset();
    a_valid = 1'b1; a_data = 8'h78; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'h79; b_last = 1'b1;
    step();
    check("t2_a_first", 32'(a_ready), 32'd1);
    check("t2_b_wait", 32'(b_ready), 32'd0);
    step();
    check("t2_a_data", 32'(m_data), 32'h58);
    check("t2_a_src", 32'(m_src), 32'd0);
    check("t2_bubble_b", 32'(b_ready), 32'd0);
    a_valid = 1'b0;
    step();
    check("t2_b_granted", 32'(b_ready), 32'd1);
    step();
    check("t2_b_data", 32'(m_data), 32'h59);
    check("t2_b_src", 32'(m_src), 32'd1);
    check("t2_b_last", 32'(m_last), 32'd1);
    a_valid = 1'b1; a_data = 8'h41;
    b_valid = 1'b1; b_data = 8'h42;
    step();
    check("t2_rr_back_a", 32'(a_ready), 32'd1);
    check("t2_rr_b_wait", 32'(b_ready), 32'd0);

    // 3: backpressure hold plus conversion boundaries
    do_reset();
    mon_q.delete();
    pkt = '{8'h61, 8'h60, 8'h7B, 8'h5B, 8'h40};
    fork
      send_a();
      begin
        step(); step(); step();
        m_ready = 1'b0;
        repeat (3) begin
          step();
          check("t3_hold_data", 32'(m_data), 32'h60);
          check("t3_hold_valid", 32'(m_valid), 32'd1);
          check("t3_hold_ready", 32'(a_ready), 32'd0);
        end
        m_ready = 1'b1;
      end
    join
    en_upper = 1'b0;
    pkt = '{8'h61};
    send_a();
    step(); step();
    en_upper = 1'b1;
    check("t3_beat_count", 32'(mon_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < mon_q.size()) check("t3_beat", 32'(mon_q[i]), 32'(exp_b[i]));
    end
    check("t3_conv_cnt", 32'(conv_cnt), 32'd1);

    // 4: watchdog drops a starved A grant, then B is served
    do_reset();
    a_valid = 1'b1; a_data = 8'h61; a_last = 1'b0;
    b_valid = 1'b1; b_data = 8'h62; b_last = 1'b1;
    step();
    check("t4_a_granted", 32'(a_ready), 32'd1);
    step();
    check("t4_a_data", 32'(m_data), 32'h41);
    check("t4_a_not_last", 32'(m_last), 32'd0);
    a_valid = 1'b0;
    repeat (15) step();
    check("t4_no_early_tout", 32'(timeout_err), 32'd0);
    check("t4_still_a", 32'(b_ready), 32'd0);
    step();
    check("t4_tout_pulse", 32'(timeout_err), 32'd1);
    check("t4_idle_b", 32'(b_ready), 32'd0);
    check("t4_no_last", 32'(m_last), 32'd0);
    step();
    check("t4_tout_cleared", 32'(timeout_err), 32'd0);
    check("t4_b_granted", 32'(b_ready), 32'd1);
    step();
    check("t4_b_data", 32'(m_data), 32'h42);
    check("t4_b_src", 32'(m_src), 32'd1);
    b_valid = 1'b0;

    // 5: reset mid-packet, then a clean packet
    do_reset();
    a_valid = 1'b1; a_data = 8'h61; a_last = 1'b0;
    step();
    step();
    check("t5_pre_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0; a_valid = 1'b0;
    step();
    check("t5_rst_valid", 32'(m_valid), 32'd0);
    check("t5_rst_data", 32'(m_data), 32'd0);
    check("t5_rst_cnt", 32'(conv_cnt), 32'd0);
    check("t5_rst_ready", 32'(a_ready), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    a_valid = 1'b1; a_data = 8'h63; a_last = 1'b1;
    step();
    step();
    check("t5_new_data", 32'(m_data), 32'h43);
    check("t5_new_last", 32'(m_last), 32'd1);
    check("t5_new_cnt", 32'(conv_cnt), 32'd1);
    a_valid = 1'b0; a_last = 1'b0;

    // 6: 2-bit counter saturates at 3
    do_reset();
    a_valid = 1'b1; a_data = 8'h61; a_last = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      a_data = 8'h61 + 8'(i);
      a_last = (i == 4);
      step();
      check("t6_cnt_sat", 32'(conv_cnt2), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end
    a_valid = 1'b0; a_last = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
